// File: rtl/apb_arbiter_master.sv
// Two-requester APB master: round-robin grant, one transfer at a time, bounded wait states.
// Every output is a flop; an abort on timeout returns zero read data with the error flag set.
module apb_arbiter_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WRITE,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]              REQ_ACCEPT,
    output logic [1:0]              REQ_DONE,
    output logic [2*DATA_WIDTH-1:0] REQ_RDATA,
    output logic [1:0]              REQ_ERR,
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [DATA_WIDTH-1:0]   PRDATA
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_q, last_d;
    logic [7:0]              wait_q, wait_d;
    logic [1:0]              accept_q, accept_d;
    logic [1:0]              done_q, done_d;
    logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              err_q, err_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    pick;

    // On contention the requester not granted last wins; otherwise the lone valid one.
    assign pick = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        wait_d    = wait_q;
        accept_d  = 2'b00;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        err_d     = err_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        unique case (state_q)
            StIdle: begin
                if (|REQ_VALID) begin
                    grant_d          = pick;
                    last_d           = pick;
                    pwrite_d         = REQ_WRITE[pick];
                    paddr_d          = REQ_ADDR[int'(pick) * ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d         = REQ_WDATA[int'(pick) * DATA_WIDTH +: DATA_WIDTH];
                    psel_d           = 1'b1;
                    penable_d        = 1'b0;
                    accept_d[pick]   = 1'b1;
                    state_d          = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                wait_d    = 8'd0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    if (!pwrite_q) begin
                        rdata_d[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH] = PRDATA;
                    end
                    err_d[grant_q]  = PSLVERR;
                    done_d[grant_q] = 1'b1;
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                    state_d         = StIdle;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    rdata_d[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH] = '0;
                    err_d[grant_q]  = 1'b1;
                    done_d[grant_q] = 1'b1;
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                    state_d         = StIdle;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            wait_q    <= 8'd0;
            accept_q  <= 2'b00;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            err_q     <= 2'b00;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            accept_q  <= accept_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign REQ_ACCEPT = accept_q;
    assign REQ_DONE   = done_q;
    assign REQ_RDATA  = rdata_q;
    assign REQ_ERR    = err_q;
    assign PSELx      = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: doc/apb_arbiter_master.md
APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL be the APB data width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL be the APB address width.
REQ-003 Parameter TIMEOUT, default 16, legal range 2..255, SHALL be the maximum number of ACCESS cycles per transfer.
REQ-004 PCLK  in  1  SHALL be the single clock; all logic rising-edge.
REQ-005 PRESET  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 REQ_VALID  in  2  SHALL be the per-requester transfer request, bit i = requester i.
REQ-007 REQ_WRITE  in  2  SHALL be the per-requester direction: 1 = write, 0 = read.
REQ-008 REQ_ADDR  in  2*ADDR_WIDTH  SHALL be the packed address; requester i uses slice i.
REQ-009 REQ_WDATA  in  2*DATA_WIDTH  SHALL be the packed write data; requester i uses slice i.
REQ-010 REQ_ACCEPT  out  2  SHALL be a one-cycle pulse: request i latched.
REQ-011 REQ_DONE  out  2  SHALL be a one-cycle pulse: transfer for requester i complete.
REQ-012 REQ_RDATA  out  2*DATA_WIDTH  SHALL be the packed read-data return per requester.
REQ-013 REQ_ERR  out  2  SHALL be the per-requester error status, valid with REQ_DONE.
REQ-014 PSELx, PENABLE, PWRITE  out  1 each  SHALL be the APB master controls.
REQ-015 PADDR  out  ADDR_WIDTH;  PWDATA  out  DATA_WIDTH  SHALL be the APB master address and data.
REQ-016 PREADY, PSLVERR  in  1 each;  PRDATA  in  DATA_WIDTH  SHALL be the slave responses.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-018 In IDLE with any REQ_VALID bit set at an edge, the block SHALL grant one requester, latch its WRITE/ADDR/WDATA, and go to SETUP.
REQ-019 Grant SHALL be round-robin: if both are valid, grant the requester not granted last; a single valid requester SHALL always be granted.
REQ-020 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-021 SETUP cycle: PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values, REQ_ACCEPT[g]=1; the next state SHALL be ACCESS unconditionally.
REQ-022 ACCESS cycles: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL be held stable.
REQ-023 At an ACCESS edge with PREADY=1, the block SHALL:
  - capture PRDATA into REQ_RDATA slice g (reads only; the slice SHALL be unchanged on writes);
  - set REQ_ERR[g]=PSLVERR;
  - pulse REQ_DONE[g];
  - drive PSELx=0, PENABLE=0;
  - go to IDLE.
REQ-024 The wait counter SHALL clear on ACCESS entry and increment per ACCESS cycle with PREADY=0.
REQ-025 At an edge with PREADY=0 and wait counter = TIMEOUT-1, the block SHALL abort: PSELx=0, PENABLE=0, REQ_DONE[g]=1, REQ_ERR[g]=1, REQ_RDATA slice g = 0, go to IDLE.
REQ-026 IDLE SHALL last at least one cycle between transfers; minimum transfer spacing is 3 cycles (IDLE, SETUP, ACCESS).
REQ-027 REQ_VALID SHALL be sampled only in IDLE; requesters hold VALID and payload until they see ACCEPT.
REQ-028 REQ_RDATA and REQ_ERR slices SHALL hold their value until the next REQ_DONE for the same requester.
REQ-029 PADDR/PWDATA/PWRITE SHALL retain their last values in IDLE.

Reset
REQ-030 With PRESET=1 at an edge, all outputs, state (IDLE), wait counter and REQ_RDATA SHALL be 0, and the pointer SHALL be 1.
REQ-031 Reset during SETUP or ACCESS SHALL abandon the transfer with no REQ_DONE pulse.

Verification
REQ-032 Single write: req0 write, addr 0x10, data 0xA5A50001, PREADY=1 -> PSELx high at T+1, PENABLE at T+2, REQ_DONE[0] at T+3, REQ_ERR[0]=0.
REQ-033 Read with wait states: req1 read, addr 0x24, PREADY low 3 ACCESS cycles, PRDATA=0xDEADBEEF -> REQ_DONE[1] after the 4th ACCESS cycle, RDATA slice1=0xDEADBEEF.
REQ-034 Contention: both requesters valid continuously after reset -> grant order 0,1,0,1; ACCEPT pulses alternate.
REQ-035 Timeout: PREADY held 0 -> exactly 16 ACCESS cycles, then PSELx=0, REQ_DONE[g]=1, REQ_ERR[g]=1, RDATA slice=0.
REQ-036 Slave error: PSLVERR=1 with PREADY=1 on a write -> REQ_ERR=1, no retry, return to IDLE.
REQ-037 Reset in the 2nd ACCESS cycle -> next cycle all outputs 0, no REQ_DONE; next contention grants requester 0.
